// File: rtl/ds_serializer_if.sv
// ============================================================================
// Module      : ds_serializer_if
// Description : Wide-in / narrow-out DataStream handshake bundle for ds_serializer.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface ds_serializer_if #(
   parameter int OWIDTH = 8,
   parameter int COUNT  = 4
) ();
   logic [OWIDTH*COUNT-1:0] i_dat;
   logic                    i_val;
   logic                    i_rdy;
   logic [OWIDTH-1:0]       o_dat;
   logic                    o_val;
   logic                    o_last;
   logic                    o_rdy;

   modport slave (
      input  i_dat, i_val, o_rdy,
      output i_rdy, o_dat, o_val, o_last
   );

   modport master (
      output i_dat, i_val, o_rdy,
      input  i_rdy, o_dat, o_val, o_last
   );
endinterface

`default_nettype wire

// File: rtl/ds_serializer.sv
// ============================================================================
// Module      : ds_serializer
// Description : Splits one COUNT*OWIDTH word into COUNT OWIDTH parts, flagging
//               the last. Macro DS_SERIALIZER_MSB_FIRST_EN selects MSB-first order.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ds_serializer #(
   parameter int OWIDTH = 8,
   parameter int COUNT  = 4
) (
   input  wire logic       clk,
   input  wire logic       reset,
   ds_serializer_if.slave  s
);
   localparam int                c_CW   = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(COUNT - 1);

   localparam logic [0:0] c_S_IDLE = 1'b0;
   localparam logic [0:0] c_S_BUSY = 1'b1;

   logic [0:0]              r_state;
   logic [0:0]              w_next;
   logic [c_CW-1:0]         r_cnt;
   logic [OWIDTH*COUNT-1:0] r_word;
   logic                    w_busy;
   logic                    w_last;
   logic                    w_load;
   logic                    w_oxfer;
   logic [OWIDTH-1:0]       w_part;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (s.i_val) begin
               w_next = c_S_BUSY;
            end
         end
         c_S_BUSY: begin
            if (s.o_rdy && w_last && !s.i_val) begin
               w_next = c_S_IDLE;
            end
         end
         default: w_next = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_busy   = (r_state == c_S_BUSY);
      w_last   = w_busy && (r_cnt == c_LAST);
      s.o_val  = w_busy;
      s.o_last = w_last;
      s.o_dat  = w_part;
      // o_rdy -> i_rdy is the single combinational path through the stage.
      s.i_rdy  = !w_busy || (s.o_rdy && w_last);
   end

   assign w_load  = s.i_val && s.i_rdy;
   assign w_oxfer = w_busy && s.o_rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (w_load) begin
         r_cnt  <= '0;
         r_word <= s.i_dat;
      end else if (w_oxfer) begin
         r_cnt  <= w_last ? '0 : r_cnt + c_CW'(1);
      end
   end

   always_comb begin
      w_part = '0;
      for (int k = 0; k < COUNT; k++) begin
         if (r_cnt == c_CW'(k)) begin
`ifdef DS_SERIALIZER_MSB_FIRST_EN
            w_part = r_word[(COUNT-1-k)*OWIDTH +: OWIDTH];
`else
            w_part = r_word[k*OWIDTH +: OWIDTH];
`endif
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_ds_serializer.sv
// ============================================================================
// Module      : tb_ds_serializer
// Description : Scoreboard bench for ds_serializer (8x4 instance and 16x1 instance).
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ds_serializer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ds_serializer_if #(.OWIDTH(8),  .COUNT(4)) ifa ();
   ds_serializer_if #(.OWIDTH(16), .COUNT(1)) ifb ();

   ds_serializer #(.OWIDTH(8),  .COUNT(4)) u_dut_a (.clk(clk), .reset(reset), .s(ifa));
   ds_serializer #(.OWIDTH(16), .COUNT(1)) u_dut_b (.clk(clk), .reset(reset), .s(ifb));

   typedef struct {
      logic [15:0] dat;
      logic        last;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   obs_a[$];
   int   obs_b[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   rnd_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ref_part(input logic [31:0] w, input int k);
      logic [31:0] t;
`ifdef DS_SERIALIZER_MSB_FIRST_EN
      t = w >> (8 * (3 - k));
`else
      t = w >> (8 * k);
`endif
      return t[7:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         ifa.o_rdy = 1'($urandom_range(0, 1));
      end
   end

   // Monitor for the 8x4 instance: parts, last flag, i_rdy rule, stall stability.
   logic       p_stall = 1'b0;
   logic [7:0] p_dat;
   logic       p_last;
   always @(negedge clk) begin
      if (reset) begin
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            check("a_hold_val", 64'(ifa.o_val), 64'd1);
            check("a_hold_dat_last", {ifa.o_dat, ifa.o_last}, {p_dat, p_last});
         end
         if (ifa.o_val) begin
            if (qa.size() == 0) begin
               check("a_unexpected_part", 64'(ifa.o_val), 64'd0);
            end else begin
               check("a_o_last", 64'(ifa.o_last), 64'(qa[0].last));
               check("a_i_rdy_busy", 64'(ifa.i_rdy), 64'(ifa.o_rdy & qa[0].last));
               if (ifa.o_rdy) begin
                  check("a_o_dat", 64'(ifa.o_dat), 64'(qa[0].dat[7:0]));
                  void'(qa.pop_front());
                  obs_a.push_back(cyc);
               end
            end
         end else begin
            check("a_i_rdy_idle", 64'(ifa.i_rdy), 64'd1);
         end
         p_stall = ifa.o_val & ~ifa.o_rdy;
         p_dat   = ifa.o_dat;
         p_last  = ifa.o_last;
      end
   end

   always @(negedge clk) begin
      if (!reset && ifb.o_val) begin
         if (qb.size() == 0) begin
            check("b_unexpected_part", 64'(ifb.o_val), 64'd0);
         end else begin
            check("b_o_last", 64'(ifb.o_last), 64'(qb[0].last));
            check("b_i_rdy", 64'(ifb.i_rdy), 64'(ifb.o_rdy));
            if (ifb.o_rdy) begin
               check("b_o_dat", 64'(ifb.o_dat), 64'(qb[0].dat));
               void'(qb.pop_front());
               obs_b.push_back(cyc);
            end
         end
      end
   end

   // Offer a word (i_val left high afterwards); expected parts given in output order.
   task automatic offer_a(input logic [31:0] w, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, output int acc);
      exp_t e;
      bit   ok = 1'b0;
      ifa.i_dat = w;
      ifa.i_val = 1'b1;
      acc = -1;
      for (int t = 0; t < 1000 && !ok; t++) begin
         @(negedge clk);
         if (ifa.i_rdy) ok = 1'b1;
      end
      check("a_accept_timeout", 64'(ok), 64'd1);
      if (ok) begin
         acc = cyc;
         e.last = 1'b0; e.dat = {8'h00, e0}; qa.push_back(e);
         e.dat = {8'h00, e1}; qa.push_back(e);
         e.dat = {8'h00, e2}; qa.push_back(e);
         e.last = 1'b1; e.dat = {8'h00, e3}; qa.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer_b(input logic [15:0] w, input logic [15:0] ex, output int acc);
      exp_t e;
      bit   ok = 1'b0;
      ifb.i_dat = w;
      ifb.i_val = 1'b1;
      acc = -1;
      for (int t = 0; t < 1000 && !ok; t++) begin
         @(negedge clk);
         if (ifb.i_rdy) ok = 1'b1;
      end
      check("b_accept_timeout", 64'(ok), 64'd1);
      if (ok) begin
         acc = cyc;
         e.dat = ex; e.last = 1'b1; qb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit sel_b);
      int t = 0;
      while (((sel_b ? qb.size() : qa.size()) != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check(sel_b ? "b_drain_timeout" : "a_drain_timeout",
            64'(sel_b ? qb.size() : qa.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2;
      logic [31:0] w;
      ifa.i_dat = '0; ifa.i_val = 1'b0; ifa.o_rdy = 1'b0;
      ifb.i_dat = '0; ifb.i_val = 1'b0; ifb.o_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("reset_state", {ifa.o_val, ifa.o_last, ifa.o_dat, ifa.i_rdy},
               {1'b0, 1'b0, 8'h00, 1'b1});
      end
      @(posedge clk); #1;

      // Single word
      ifa.o_rdy = 1'b1;
      obs_a.delete();
`ifdef DS_SERIALIZER_MSB_FIRST_EN
      offer_a(32'hA1B2C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4, acc);
`else
      offer_a(32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1, acc);
`endif
      ifa.i_val = 1'b0;
      drain(1'b0);
      check("single_count", 64'(obs_a.size()), 64'd4);
      if (obs_a.size() == 4) begin
         check("single_latency", 64'(obs_a[0]), 64'(acc + 1));
         check("single_consecutive", 64'(obs_a[3] - obs_a[0]), 64'd3);
      end

      // Back-to-back words, no bubble
      obs_a.delete();
`ifdef DS_SERIALIZER_MSB_FIRST_EN
      offer_a(32'h03020100, 8'h03, 8'h02, 8'h01, 8'h00, acc);
      offer_a(32'h07060504, 8'h07, 8'h06, 8'h05, 8'h04, acc2);
`else
      offer_a(32'h03020100, 8'h00, 8'h01, 8'h02, 8'h03, acc);
      offer_a(32'h07060504, 8'h04, 8'h05, 8'h06, 8'h07, acc2);
`endif
      ifa.i_val = 1'b0;
      drain(1'b0);
      check("b2b_count", 64'(obs_a.size()), 64'd8);
      if (obs_a.size() == 8) begin
         check("b2b_no_bubble", 64'(obs_a[7] - obs_a[0]), 64'd7);
         check("b2b_second_accept", 64'(acc2 - acc), 64'd4);
      end

      // Random stalls over 100 random words
      rnd_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         w = $urandom;
         offer_a(w, ref_part(w, 0), ref_part(w, 1), ref_part(w, 2), ref_part(w, 3), acc);
         if ($urandom_range(0, 3) == 0) begin
            ifa.i_val = 1'b0;
            @(posedge clk); #1;
         end
      end
      ifa.i_val = 1'b0;
      drain(1'b0);
      rnd_en = 1'b0;
      @(posedge clk); #2;
      ifa.o_rdy = 1'b1;

      // Reset after two of four parts
`ifdef DS_SERIALIZER_MSB_FIRST_EN
      offer_a(32'h44332211, 8'h44, 8'h33, 8'h22, 8'h11, acc);
`else
      offer_a(32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44, acc);
`endif
      ifa.i_val = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      ifa.o_rdy = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("parts_before_reset_left", 64'(qa.size()), 64'd2);
      qa.delete();
      ifa.o_rdy = 1'b1;
      @(negedge clk);
      check("o_val_after_reset", 64'(ifa.o_val), 64'd0);
      repeat (5) @(posedge clk);
      #1;
`ifdef DS_SERIALIZER_MSB_FIRST_EN
      offer_a(32'h88776655, 8'h88, 8'h77, 8'h66, 8'h55, acc);
`else
      offer_a(32'h88776655, 8'h55, 8'h66, 8'h77, 8'h88, acc);
`endif
      ifa.i_val = 1'b0;
      drain(1'b0);

      // COUNT=1 instance
      obs_b.delete();
      offer_b(16'h1234, 16'h1234, acc);
      offer_b(16'h5678, 16'h5678, acc2);
      ifb.i_val = 1'b0;
      drain(1'b1);
      check("c1_count", 64'(obs_b.size()), 64'd2);
      if (obs_b.size() == 2) begin
         check("c1_latency", 64'(obs_b[0]), 64'(acc + 1));
         check("c1_throughput", 64'(obs_b[1] - obs_b[0]), 64'd1);
         check("c1_second_accept", 64'(acc2 - acc), 64'd1);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
